// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Drives an 8-digit multiplexed common-anode 7-segment display from a 32-bit
// value. One digit is lit per slot of REFRESH_DIV clocks; the inputs
// {o_bin, disp8, off} are captured once per frame so a frame never mixes two
// values. an/seg/dp are active-low and registered.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading-zero digits
// within the active width (digit 0 is always shown).
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int N_DIGITS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] o_bin,
    input  logic        disp8,
    input  logic        off,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

    // Catch misconfiguration at elaboration time.
    generate
        if (REFRESH_DIV < 2) begin : g_bad_div
            $error("seven_seg_scan_driver: REFRESH_DIV must be >= 2");
        end
        if (N_DIGITS != 8) begin : g_bad_digits
            $error("seven_seg_scan_driver: N_DIGITS must be 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDX0, IDX1, IDX2, IDX3, IDX4, IDX5, IDX6, IDX7
    } digit_e;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    digit_e           digit_q, digit_d;
    logic [31:0]      snap_bin_q, snap_bin_d;
    logic             snap_d8_q, snap_d8_d;
    logic             snap_off_q, snap_off_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             tick;
    logic             frame_tick;
    logic [2:0]       slot;
    logic             blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic [31:0]      active_bin;
`endif

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        unique case (nib)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Slot divider and once-per-frame input snapshot.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        tick       = (div_cnt_q == DIV_MAX);
        frame_tick = tick && (digit_q == IDX7);
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        snap_bin_d = snap_bin_q;
        snap_d8_d  = snap_d8_q;
        snap_off_d = snap_off_q;
        if (frame_tick) begin
            snap_bin_d = o_bin;
            snap_d8_d  = disp8;
            snap_off_d = off;
        end
    end

    // Digit FSM next state and anode/segment decode for the current slot.
    always_comb begin
        digit_d = digit_q;
        if (tick) begin
            digit_d = digit_e'(digit_q + 3'd1);
        end
        slot  = digit_q;
        blank = snap_off_q || (!snap_d8_q && slot[2]);
`ifdef LEADING_ZERO_BLANK_EN
        // Only nibbles inside the active width count as "higher" digits.
        active_bin = snap_d8_q ? snap_bin_q : {16'h0000, snap_bin_q[15:0]};
        if ((slot != 3'd0) && ((active_bin >> {slot, 2'b00}) == 32'h0)) begin
            blank = 1'b1;
        end
`endif
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (!blank) begin
            an_d  = ~(8'b1 << slot);
            seg_d = hex7(snap_bin_q[{slot, 2'b00} +: 4]);
        end
    end

    // Digit FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (reset) begin
            digit_q <= IDX0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Divider, snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            snap_bin_q <= 32'h0;
            snap_d8_q  <= 1'b0;
            snap_off_q <= 1'b0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
        end else begin
            div_cnt_q  <= div_cnt_d;
            snap_bin_q <= snap_bin_d;
            snap_d8_q  <= snap_d8_d;
            snap_off_q <= snap_off_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = 1'b1;
    assign frame_start = frame_tick && !reset;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (REFRESH_DIV=4).
// The reference model tracks elapsed clocks since reset release and derives
// the lit slot, the displayed frame snapshot and the expected patterns from
// plain arithmetic on that count.
module tb_seven_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] o_bin = 32'h0;
    logic        disp8 = 1'b0;
    logic        off   = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int t      = 0;

    // Snapshot currently on display, and the one captured for the next frame.
    logic [31:0] cur_bin = 32'h0, pend_bin = 32'h0;
    logic        cur_d8 = 1'b0, pend_d8 = 1'b0;
    logic        cur_off = 1'b0, pend_off = 1'b0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_seg_scan_driver #(.REFRESH_DIV(DIV), .N_DIGITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .o_bin       (o_bin),
        .disp8       (disp8),
        .off         (off),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic model_blank(input int k);
        int width;
        logic all_zero;
        width = cur_d8 ? 8 : 4;
        if (cur_off) return 1'b1;
        if (k >= width) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0) begin
            all_zero = 1'b1;
            for (int j = k; j < width; j++) begin
                if (cur_bin[4*j +: 4] != 4'h0) all_zero = 1'b0;
            end
            if (all_zero) return 1'b1;
        end
`else
        all_zero = 1'b0;
`endif
        return all_zero & 1'b0;
    endfunction

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic cycle();
        int          k;
        logic        blk;
        logic [7:0]  one_hot;
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_fs;
        @(posedge clk);
        if (reset) begin
            t = 0;
            cur_bin = 32'h0; cur_d8 = 1'b0; cur_off = 1'b0;
            pend_bin = 32'h0; pend_d8 = 1'b0; pend_off = 1'b0;
        end else begin
            t++;
            if ((t % FRAME == 1) && (t > FRAME)) begin
                cur_bin = pend_bin; cur_d8 = pend_d8; cur_off = pend_off;
            end
            if (t % FRAME == 0) begin
                pend_bin = o_bin; pend_d8 = disp8; pend_off = off;
            end
        end
        @(negedge clk);
        if (t == 0) begin
            blk     = 1'b1;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            exp_fs  = 1'b0;
        end else begin
            k       = ((t - 1) / DIV) % 8;
            blk     = model_blank(k);
            one_hot = 8'b1 << k;
            exp_an  = blk ? 8'hFF : ~one_hot;
            exp_seg = blk ? 7'h7F : hex_tab[cur_bin[4*k +: 4]];
            exp_fs  = ((t % FRAME) == FRAME - 1);
        end
        check("an", {24'h0, an}, {24'h0, exp_an});
        check("seg", {25'h0, seg}, {25'h0, exp_seg});
        check("dp", {31'h0, dp}, 32'h1);
        check("frame_start", {31'h0, frame_start}, {31'h0, exp_fs});
        check("an_lit_count", $countones(~an), blk ? 32'd0 : 32'd1);
    endtask

    initial begin
        // Held in reset: display dark, no frame pulse.
        repeat (3) cycle();
        reset = 1'b0;

        // First frame after release shows snapshot 0.
        repeat (FRAME) cycle();

        // Four-digit mode.
        o_bin = 32'h0000_12AF; disp8 = 1'b0;
        repeat (2 * FRAME) cycle();

        // Eight-digit mode.
        o_bin = 32'hDEAD_BEEF; disp8 = 1'b1;
        repeat (2 * FRAME) cycle();

        // Change during slot 3: must not tear the current frame.
        repeat (14) cycle();
        o_bin = $urandom;
        repeat (FRAME + 18) cycle();

        // off overrides disp8; releasing it mid-frame waits for next frame.
        off = 1'b1; disp8 = 1'b1;
        repeat (FRAME + 10) cycle();
        off = 1'b0;
        repeat (2 * FRAME + 22) cycle();

        // Randomized inputs changing at arbitrary points in the frame.
        repeat (10) begin
            o_bin = $urandom >> $urandom_range(0, 31);
            disp8 = 1'($urandom_range(0, 1));
            off   = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(5, 40)) cycle();
        end

        // Reset asserted while slot 5 is lit.
        o_bin = 32'h0000_0030; disp8 = 1'b0; off = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((t > 0) && (((t - 1) / DIV) % 8 == 5)) break;
            cycle();
        end
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (3 * FRAME) cycle();

        // All-zero value in eight-digit mode.
        o_bin = 32'h0; disp8 = 1'b1;
        repeat (2 * FRAME) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout t=%0d", t);
        $fatal(1, "timeout");
    end

endmodule
